// File: rtl/fibonacci_lanes.sv
// Multi-lane Fibonacci stream generator: LANES consecutive terms per beat, seeded and length-programmed.
// Define FIBONACCI_LANES_SAT_EN to saturate overflowed terms to all-ones instead of wrapping.
module fibonacci_lanes #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed_a,
  input  logic [WIDTH-1:0]       seed_b,
  input  logic [15:0]            len,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             xo_q, xo_d, yo_q, yo_d;
  logic [15:0]      rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] term  [LANES+2];
  logic             tovf  [LANES+2];
  logic [WIDTH:0]   sum_w [LANES];
  logic             beat_ovf;
  logic             accept;

`ifdef FIBONACCI_LANES_SAT_EN
  function automatic logic [WIDTH-1:0] sat_term(input logic [WIDTH-1:0] v, input logic flag);
    return flag ? {WIDTH{1'b1}} : v;
  endfunction
`endif

  // Term chain: term[0..1] are the held pair, term[LANES..LANES+1] the look-ahead pair.
  // A term's overflow tag covers its own carry and any tagged operand.
  always_comb begin
    term[0] = x_q;
    tovf[0] = xo_q;
    term[1] = y_q;
    tovf[1] = yo_q;
    for (int k = 2; k < LANES + 2; k++) begin
      sum_w[k-2] = {1'b0, term[k-1]} + {1'b0, term[k-2]};
      tovf[k]    = sum_w[k-2][WIDTH] | tovf[k-1] | tovf[k-2];
`ifdef FIBONACCI_LANES_SAT_EN
      term[k]    = sat_term(sum_w[k-2][WIDTH-1:0], tovf[k]);
`else
      term[k]    = sum_w[k-2][WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    out_data = '0;
    out_keep = '0;
    beat_ovf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (state_q == RUN && rem_q > 16'(k)) begin
        out_keep[k]                = 1'b1;
        out_data[k*WIDTH +: WIDTH] = term[k];
        beat_ovf                   = beat_ovf | tovf[k];
      end
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_last  = (state_q == RUN) && (rem_q <= 16'(LANES));
  assign overflow  = ovf_q | beat_ovf;
  assign accept    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q | beat_ovf;
    case (state_q)
      IDLE: begin
        if (start && len != 16'd0) begin
          state_d = RUN;
          x_d     = seed_a;
          y_d     = seed_b;
          xo_d    = 1'b0;
          yo_d    = 1'b0;
          rem_d   = len;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          x_d  = term[LANES];
          xo_d = tovf[LANES];
          y_d  = term[LANES+1];
          yo_d = tovf[LANES+1];
          if (out_last) begin
            rem_d   = 16'd0;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - 16'(LANES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  // Term registers need no reset: every output lane is gated by state.
  always_ff @(posedge clk) begin
    x_q  <= x_d;
    y_q  <= y_d;
    xo_q <= xo_d;
    yo_q <= yo_d;
  end

endmodule

// File: tb/tb_fibonacci_lanes.sv
// Scoreboard bench for fibonacci_lanes at WIDTH=16, LANES=2.
module tb_fibonacci_lanes;
  localparam int W = 16;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           rst, start, out_ready;
  logic           out_valid, out_last, busy, overflow;
  logic [W-1:0]   seed_a, seed_b;
  logic [15:0]    len;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_keep;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [L*W-1:0] data;
    logic [L-1:0]   keep;
    logic           last;
    logic           ovf;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t seen_q[$];
  int    first_c;

  always #5 clk = ~clk;

  fibonacci_lanes #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b), .len(len),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  // Reference beats from exact integer Fibonacci; ovf marks a kept lane whose true value exceeds 16 bits.
  function automatic void push_expected(input longint a, input longint b, input int n);
    longint f[$];
    longint v;
    beat_t  bt;
    f.push_back(a);
    f.push_back(b);
    for (int i = 2; i < n + L; i++) f.push_back(f[i-1] + f[i-2]);
    for (int base = 0; base < n; base += L) begin
      bt = '0;
      for (int k = 0; k < L; k++) begin
        if (base + k < n) begin
          v = f[base+k];
          bt.keep[k] = 1'b1;
          if (v > 65535) begin
            bt.ovf = 1'b1;
`ifdef FIBONACCI_LANES_SAT_EN
            bt.data[k*W +: W] = 16'hFFFF;
`else
            bt.data[k*W +: W] = v[15:0];
`endif
          end else begin
            bt.data[k*W +: W] = v[15:0];
          end
        end
      end
      bt.last = (n - base <= L);
      exp_q.push_back(bt);
    end
  endfunction

  task automatic issue_start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    seed_a = a;
    seed_b = b;
    len    = n;
    start  = 1'b1;
  endtask

  // Observe beats; ready is dropped for stall_n valid cycles starting at valid cycle stall_at.
  task automatic collect(input int max_cycles, input int stall_at, input int stall_n, output bit done);
    int    vc;
    beat_t bt;
    vc      = 0;
    done    = 1'b0;
    first_c = -1;
    got_q.delete();
    seen_q.delete();
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = !(vc >= stall_at && vc < stall_at + stall_n);
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        bt.data = out_data;
        bt.keep = out_keep;
        bt.last = out_last;
        bt.ovf  = overflow;
        seen_q.push_back(bt);
        if (out_ready) begin
          got_q.push_back(bt);
          if (out_last) done = 1'b1;
        end
        vc++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; seed_a = '0; seed_b = '0; len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b last=%b ovf=%b, expected all 0", out_valid, busy, out_last, overflow);
    end
    checks++;
    if (out_data !== '0 || out_keep !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h keep=%b, expected 0", out_data, out_keep);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit    done;
    beat_t e, g;
    push_expected(1, 1, 6);
    issue_start(16'd1, 16'd1, 16'd6);
    collect(20, 0, 0, done);
    checks++;
    if (!done || first_c != 0 || seen_q.size() != 3) begin
      errors++;
      $display("FAIL basic_timing: done=%0d first=%0d valid_cycles=%0d, expected 1 0 3", done, first_c, seen_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last) begin
        errors++;
        $display("FAIL basic_beat: got %h/%b/%b, expected %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: busy=%b valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_partial;
    bit    done;
    beat_t e, g;
    push_expected(1, 1, 5);
    issue_start(16'd1, 16'd1, 16'd5);
    collect(20, 0, 0, done);
    checks++;
    if (!done || got_q.size() != 3) begin
      errors++;
      $display("FAIL partial_count: done=%0d beats=%0d, expected 1 3", done, got_q.size());
    end else begin
      checks++;
      if (got_q[2].data !== 32'h0000_0005 || got_q[2].keep !== 2'b01 || got_q[2].last !== 1'b1) begin
        errors++;
        $display("FAIL partial_last: got %h/%b/%b, expected 00000005/01/1", got_q[2].data, got_q[2].keep, got_q[2].last);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last) begin
        errors++;
        $display("FAIL partial_beat: got %h/%b/%b, expected %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit    done;
    beat_t e, g;
    push_expected(0, 1, 4);
    issue_start(16'd0, 16'd1, 16'd4);
    collect(20, 0, 3, done);
    checks++;
    if (!done || seen_q.size() != 5 || got_q.size() != 2) begin
      errors++;
      $display("FAIL bp_count: done=%0d seen=%0d accepted=%0d, expected 1 5 2", done, seen_q.size(), got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen_q[i].data !== 32'h0001_0000 || seen_q[i].keep !== 2'b11 || seen_q[i].last !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold%0d: got %h/%b/%b, expected 00010000/11/0", i, seen_q[i].data, seen_q[i].keep, seen_q[i].last);
        end
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last) begin
        errors++;
        $display("FAIL bp_beat: got %h/%b/%b, expected %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_overflow;
    bit           done;
    bit           acc;
    beat_t        e, g;
    logic [15:0]  t24;
`ifdef FIBONACCI_LANES_SAT_EN
    t24 = 16'd65535;
`else
    t24 = 16'd9489;
`endif
    push_expected(1, 1, 26);
    issue_start(16'd1, 16'd1, 16'd26);
    collect(60, 0, 0, done);
    checks++;
    if (!done || got_q.size() != 13) begin
      errors++;
      $display("FAIL ovf_count: done=%0d beats=%0d, expected 1 13", done, got_q.size());
    end else begin
      checks++;
      if (got_q[12].data[15:0] !== t24 || got_q[11].data[31:16] !== 16'd46368) begin
        errors++;
        $display("FAIL ovf_terms: t24=%0d t23=%0d, expected %0d 46368", got_q[12].data[15:0], got_q[11].data[31:16], t24);
      end
      checks++;
      if (got_q[11].ovf !== 1'b0 || got_q[12].ovf !== 1'b1) begin
        errors++;
        $display("FAIL ovf_rise: beat11=%b beat12=%b, expected 0 1", got_q[11].ovf, got_q[12].ovf);
      end
    end
    acc = 1'b0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      acc = acc | e.ovf;
      checks++;
      if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last || g.ovf !== acc) begin
        errors++;
        $display("FAIL ovf_beat: got %h/%b/%b ovf=%b, expected %h/%b/%b ovf=%b", g.data, g.keep, g.last, g.ovf, e.data, e.keep, e.last, acc);
      end
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b busy=%b, expected 1 0", overflow, busy);
    end
  endtask

  task automatic test_reset_ignored;
    bit    done;
    beat_t e, g;
    issue_start(16'd40000, 16'd40000, 16'd10);
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: valid=%b overflow=%b, expected 1 1", out_valid, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out_keep !== '0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b busy=%b overflow=%b keep=%b, expected 0 0 0 00", out_valid, busy, overflow, out_keep);
    end
    issue_start(16'd5, 16'd5, 16'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_start: valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
    push_expected(2, 3, 6);
    issue_start(16'd2, 16'd3, 16'd6);
    @(negedge clk);
    out_ready = 1'b0;
    seed_a    = 16'd9;
    seed_b    = 16'd9;
    len       = 16'd2;
    start     = 1'b1;
    checks++;
    if (out_data !== 32'h0003_0002 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_first: data=%h busy=%b, expected 00030002 1", out_data, busy);
    end
    collect(20, 0, 0, done);
    checks++;
    if (!done || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL busy_start_count: done=%0d beats=%0d, expected 1 %0d", done, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last || g.ovf !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_beat: got %h/%b/%b ovf=%b, expected %h/%b/%b ovf=0", g.data, g.keep, g.last, g.ovf, e.data, e.keep, e.last);
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_overflow();
    test_reset_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
